// File: rtl/v_pkg.sv
// Shared types and constants for the vector
// coprocessor clock-gating controller.
package v_pkg;

  typedef enum logic [1:0] {
    CG_OFF,
    CG_WAKE,
    CG_ON,
    CG_HOLD
  } cg_state_t;

  localparam int CG_WAKE_DEF = 2;
  localparam int CG_HOLD_DEF = 4;

  localparam int CG_VALU  = 0;
  localparam int CG_VMUL  = 1;
  localparam int CG_VRED  = 2;
  localparam int CG_VSLDU = 3;
  localparam int CG_VLSU  = 4;

endpackage

// File: rtl/v_clkgate_unit.sv
// One gated channel: wake/hold FSM, countdown,
// busy tracking and sticky done-without-busy error.
module v_clkgate_unit
  import v_pkg::*;
#(
  parameter int WAKE_CYCLES = CG_WAKE_DEF,
  parameter int HOLD_CYCLES = CG_HOLD_DEF,
  parameter int CNT_W       = 8
) (
  input  logic clk,
  input  logic nrst,
  input  logic req,
  input  logic done,
  input  logic force_on,
  output logic gate_en,
  output logic ready,
  output logic busy,
  output logic err
);

  localparam logic [CNT_W-1:0] WAKE_LD =
    CNT_W'(WAKE_CYCLES > 0 ? WAKE_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] HOLD_LD =
    CNT_W'(HOLD_CYCLES > 0 ? HOLD_CYCLES - 1 : 0);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  cg_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             gate_q, gate_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             accept;

  // Next state, countdown and status bits; CE/ready
  // are decoded from the next state so they leave
  // the register cleanly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = req & ready_q;
    busy_d  = accept | (busy_q & ~done);
    err_d   = err_q | (done & ~busy_q);
    unique case (state_q)
      CG_OFF: begin
        if (req | force_on) begin
          if (WAKE_CYCLES > 0) begin
            state_d = CG_WAKE;
            cnt_d   = WAKE_LD;
          end else begin
            state_d = CG_ON;
          end
        end
      end
      CG_WAKE: begin
        if (cnt_q == '0) begin
          state_d = CG_ON;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      CG_ON: begin
        if (!req && !busy_d && !force_on) begin
          if (HOLD_CYCLES > 0) begin
            state_d = CG_HOLD;
            cnt_d   = HOLD_LD;
          end else begin
            state_d = CG_OFF;
          end
        end
      end
      CG_HOLD: begin
        if (req | force_on) begin
          state_d = CG_ON;
        end else if (cnt_q == '0) begin
          state_d = CG_OFF;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      default: state_d = CG_OFF;
    endcase
    gate_d  = (state_d != CG_OFF);
    ready_d = (state_d == CG_ON) |
              (state_d == CG_HOLD);
  end

  // State and registered outputs; reset drops any
  // in-flight busy state.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q <= CG_OFF;
      cnt_q   <= '0;
      gate_q  <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gate_q  <= gate_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  assign gate_en = gate_q;
  assign ready   = ready_q;
  assign busy    = busy_q;
  assign err     = err_q;

endmodule

// File: rtl/v_clkgate_ctrl.sv
// Clock-gating controller top: one FSM per vector
// unit, plus the shared stall and error reduction.
module v_clkgate_ctrl
  import v_pkg::*;
#(
  parameter int NUM_UNITS   = 5,
  parameter int WAKE_CYCLES = CG_WAKE_DEF,
  parameter int HOLD_CYCLES = CG_HOLD_DEF,
  parameter int CNT_W       = 8
) (
  input  logic                 clk,
  input  logic                 nrst,
  input  logic [NUM_UNITS-1:0] unit_req,
  input  logic [NUM_UNITS-1:0] unit_done,
  input  logic                 force_on,
  output logic [NUM_UNITS-1:0] gate_en,
  output logic [NUM_UNITS-1:0] unit_ready,
  output logic [NUM_UNITS-1:0] unit_busy,
  output logic                 stall,
  output logic                 err
);

  logic [NUM_UNITS-1:0] err_u;

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_unit
    v_clkgate_unit #(
      .WAKE_CYCLES (WAKE_CYCLES),
      .HOLD_CYCLES (HOLD_CYCLES),
      .CNT_W       (CNT_W)
    ) u_unit (
      .clk      (clk),
      .nrst     (nrst),
      .req      (unit_req[g]),
      .done     (unit_done[g]),
      .force_on (force_on),
      .gate_en  (gate_en[g]),
      .ready    (unit_ready[g]),
      .busy     (unit_busy[g]),
      .err      (err_u[g])
    );
  end

  assign stall = |(unit_req & ~unit_ready);
  assign err   = |err_u;

endmodule

// File: tb/tb_v_clkgate_ctrl.sv
// Directed bench for the clock-gating controller
// at default parameters.
module tb_v_clkgate_ctrl;

  logic       clk;
  logic       nrst;
  logic [4:0] unit_req;
  logic [4:0] unit_done;
  logic       force_on;
  logic [4:0] gate_en;
  logic [4:0] unit_ready;
  logic [4:0] unit_busy;
  logic       stall;
  logic       err;

  int n_chk = 0;
  int n_err = 0;

  v_clkgate_ctrl #(
    .NUM_UNITS   (5),
    .WAKE_CYCLES (2),
    .HOLD_CYCLES (4),
    .CNT_W       (8)
  ) dut (
    .clk        (clk),
    .nrst       (nrst),
    .unit_req   (unit_req),
    .unit_done  (unit_done),
    .force_on   (force_on),
    .gate_en    (gate_en),
    .unit_ready (unit_ready),
    .unit_busy  (unit_busy),
    .stall      (stall),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // row bits: {req, done, gate, ready, busy, stall}
  // for unit 1; other units must stay zero.
  logic [5:0] tab_a [12] = '{
    6'b100001, 6'b101001, 6'b101001, 6'b101100,
    6'b001110, 6'b001110, 6'b011110, 6'b001100,
    6'b001100, 6'b001100, 6'b001100, 6'b000000
  };

  logic [5:0] tab_b [17] = '{
    6'b100001, 6'b101001, 6'b101001, 6'b101100,
    6'b001110, 6'b001110, 6'b011110, 6'b001100,
    6'b001100, 6'b101100, 6'b001110, 6'b011110,
    6'b001100, 6'b001100, 6'b001100, 6'b001100,
    6'b000000
  };

  task automatic run_row(input string pfx,
                         input int c,
                         input logic [5:0] r);
    logic [4:0] u1;
    u1 = 5'b00010;
    unit_req  = r[5] ? u1 : 5'b0;
    unit_done = r[4] ? u1 : 5'b0;
    #1;
    chk($sformatf("%s%0d_gate", pfx, c),
        int'(gate_en), int'(r[3] ? u1 : 5'b0));
    chk($sformatf("%s%0d_ready", pfx, c),
        int'(unit_ready), int'(r[2] ? u1 : 5'b0));
    chk($sformatf("%s%0d_busy", pfx, c),
        int'(unit_busy), int'(r[1] ? u1 : 5'b0));
    chk($sformatf("%s%0d_stall", pfx, c),
        int'(stall), int'(r[0]));
    tick();
  endtask

  initial begin
    nrst      = 1'b0;
    unit_req  = '0;
    unit_done = '0;
    force_on  = 1'b0;
    tick();
    tick();
    chk("rst_gate", int'(gate_en), 0);
    chk("rst_ready", int'(unit_ready), 0);
    chk("rst_err", int'(err), 0);
    nrst = 1'b1;
    repeat (10) tick();
    #1;
    chk("idle_gate", int'(gate_en), 0);
    chk("idle_ready", int'(unit_ready), 0);
    chk("idle_busy", int'(unit_busy), 0);
    chk("idle_stall", int'(stall), 0);
    chk("idle_err", int'(err), 0);
    tick();

    // wake, accept, done, hold expiry on unit 1
    for (int c = 0; c < 12; c++)
      run_row("A", c, tab_a[c]);
    unit_req  = '0;
    unit_done = '0;

    // re-request while in HOLD
    for (int c = 0; c < 17; c++)
      run_row("B", c, tab_b[c]);
    unit_req  = '0;
    unit_done = '0;
    chk("B_err", int'(err), 0);

    // global force-on for 20 cycles
    for (int c = 0; c < 26; c++) begin
      force_on = (c < 20);
      #1;
      chk($sformatf("F%0d_gate", c), int'(gate_en),
          (c >= 1 && c <= 24) ? 31 : 0);
      chk($sformatf("F%0d_ready", c),
          int'(unit_ready),
          (c >= 3 && c <= 24) ? 31 : 0);
      chk($sformatf("F%0d_stall", c), int'(stall), 0);
      tick();
    end
    force_on = 1'b0;

    // done on idle unit 0 raises sticky err
    unit_done = 5'b00001;
    #1;
    chk("E_err_pre", int'(err), 0);
    tick();
    unit_done = '0;
    #1;
    chk("E_err_set", int'(err), 1);
    chk("E_busy", int'(unit_busy), 0);
    repeat (3) tick();
    chk("E_err_hold", int'(err), 1);

    // async reset in the middle of unit 2 wake-up
    unit_req = 5'b00100;
    #1;
    chk("R_stall0", int'(stall), 1);
    tick();
    #1;
    chk("R_gate1", int'(gate_en), 4);
    chk("R_ready1", int'(unit_ready), 0);
    nrst = 1'b0;
    #1;
    chk("R_gate_clr", int'(gate_en), 0);
    chk("R_err_clr", int'(err), 0);
    chk("R_stall", int'(stall), 1);
    unit_req = '0;
    tick();
    nrst = 1'b1;
    tick();

    // every unit requested together
    unit_req = 5'b11111;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk($sformatf("P%0d_gate", c), int'(gate_en),
          c >= 1 ? 31 : 0);
      chk($sformatf("P%0d_ready", c),
          int'(unit_ready), c >= 3 ? 31 : 0);
      chk($sformatf("P%0d_stall", c), int'(stall),
          c < 3 ? 1 : 0);
      tick();
    end
    unit_req = '0;
    #1;
    chk("P4_busy", int'(unit_busy), 31);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
